// File: rtl/dm_sba_arb.sv
// dm_sba_arb: shares the DM's single IBP master port between the abstract-command
// memory engine (r0) and the sbcs/sbdata system-bus engine (r1). Round-robin
// grant, held until the owner's traffic has drained, with bounds on outstanding
// commands and on commands per grant.
module dm_sba_arb #(
   parameter int SBA_ADDR_W = 32,
   parameter int SBA_DATA_W = 64,
   parameter int MAX_OUT    = 2,
   parameter int MAX_GRANT  = 4
) (
   input  logic                      clk,
   input  logic                      rst_a,
   input  logic                      dm_active,
   // requester 0
   input  logic                      r0_cmd_valid,
   output logic                      r0_cmd_accept,
   input  logic                      r0_cmd_read,
   input  logic [SBA_ADDR_W-1:0]     r0_cmd_addr,
   input  logic [3:0]                r0_cmd_space,
   input  logic [3:0]                r0_cmd_burst,
   input  logic                      r0_wr_valid,
   input  logic                      r0_wr_last,
   input  logic [SBA_DATA_W-1:0]     r0_wr_data,
   input  logic [SBA_DATA_W/8-1:0]   r0_wr_mask,
   output logic                      r0_wr_accept,
   output logic                      r0_rd_valid,
   output logic                      r0_rd_err,
   output logic                      r0_rd_last,
   output logic [SBA_DATA_W-1:0]     r0_rd_data,
   input  logic                      r0_rd_accept,
   output logic                      r0_wr_done,
   output logic                      r0_wr_err,
   input  logic                      r0_wr_resp_accept,
   // requester 1
   input  logic                      r1_cmd_valid,
   output logic                      r1_cmd_accept,
   input  logic                      r1_cmd_read,
   input  logic [SBA_ADDR_W-1:0]     r1_cmd_addr,
   input  logic [3:0]                r1_cmd_space,
   input  logic [3:0]                r1_cmd_burst,
   input  logic                      r1_wr_valid,
   input  logic                      r1_wr_last,
   input  logic [SBA_DATA_W-1:0]     r1_wr_data,
   input  logic [SBA_DATA_W/8-1:0]   r1_wr_mask,
   output logic                      r1_wr_accept,
   output logic                      r1_rd_valid,
   output logic                      r1_rd_err,
   output logic                      r1_rd_last,
   output logic [SBA_DATA_W-1:0]     r1_rd_data,
   input  logic                      r1_rd_accept,
   output logic                      r1_wr_done,
   output logic                      r1_wr_err,
   input  logic                      r1_wr_resp_accept,
   // IBP master
   output logic                      m_cmd_valid,
   input  logic                      m_cmd_accept,
   output logic                      m_cmd_read,
   output logic [SBA_ADDR_W-1:0]     m_cmd_addr,
   output logic [3:0]                m_cmd_space,
   output logic [3:0]                m_cmd_burst,
   output logic                      m_wr_valid,
   input  logic                      m_wr_accept,
   output logic                      m_wr_last,
   output logic [SBA_DATA_W-1:0]     m_wr_data,
   output logic [SBA_DATA_W/8-1:0]   m_wr_mask,
   input  logic                      m_rd_valid,
   output logic                      m_rd_accept,
   input  logic                      m_rd_err,
   input  logic                      m_rd_last,
   input  logic [SBA_DATA_W-1:0]     m_rd_data,
   input  logic                      m_wr_done,
   input  logic                      m_wr_err,
   output logic                      m_wr_resp_accept,
   output logic                      proto_err
);

   localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);
   localparam logic [3:0] MAX_GNT_C = 4'(MAX_GRANT);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

   owner_t      owner_q, owner_d;
   logic        last_q, last_d;
   logic [2:0]  out_cnt_q, out_cnt_d;
   logic [2:0]  wdat_cnt_q, wdat_cnt_d;
   logic [3:0]  gnt_cnt_q, gnt_cnt_d;
   logic        proto_err_q, proto_err_d;

   logic sel1, owning, own0, own1, acc_idle;
   logic c_valid, oth_valid, w_valid, rd_acc, wrr_acc;
   logic drained, yield, rel, cmd_ok, cmd_hs, wr_gate, wr_hs_cmd, wlast_hs;
   logic rd_ok, wr_ok, rd_fin, wr_fin, rd_stray, wr_stray;

   // Owner-selected pass-through of all channels plus handshake qualification.
   always_comb begin
      sel1     = (owner_q == OWN1);
      owning   = dm_active & ((owner_q == OWN0) | (owner_q == OWN1));
      own0     = owning & ~sel1;
      own1     = owning & sel1;
      // Stray-response drain in IDLE, suppressed while reset is asserted.
      acc_idle = dm_active & ~rst_a & (owner_q == IDLE);

      c_valid   = sel1 ? r1_cmd_valid      : r0_cmd_valid;
      oth_valid = sel1 ? r0_cmd_valid      : r1_cmd_valid;
      w_valid   = sel1 ? r1_wr_valid       : r0_wr_valid;
      rd_acc    = sel1 ? r1_rd_accept      : r0_rd_accept;
      wrr_acc   = sel1 ? r1_wr_resp_accept : r0_wr_resp_accept;

      drained = (out_cnt_q == 3'd0) & (wdat_cnt_q == 3'd0);
      // A drained owner with a competitor waiting hands over; block its cmd that
      // same clock so nothing is accepted on the way out.
      yield   = oth_valid & (gnt_cnt_q != 4'd0) & drained;
      rel     = drained & (~c_valid | (gnt_cnt_q == MAX_GNT_C) | yield);
      cmd_ok  = (out_cnt_q < MAX_OUT_C) & (gnt_cnt_q < MAX_GNT_C) & ~yield;

      m_cmd_valid = owning & c_valid & cmd_ok;
      m_cmd_read  = owning & (sel1 ? r1_cmd_read : r0_cmd_read);
      m_cmd_addr  = owning ? (sel1 ? r1_cmd_addr  : r0_cmd_addr)  : '0;
      m_cmd_space = owning ? (sel1 ? r1_cmd_space : r0_cmd_space) : '0;
      m_cmd_burst = owning ? (sel1 ? r1_cmd_burst : r0_cmd_burst) : '0;
      cmd_hs      = m_cmd_valid & m_cmd_accept;
      r0_cmd_accept = own0 & m_cmd_accept & cmd_ok;
      r1_cmd_accept = own1 & m_cmd_accept & cmd_ok;

      // Write data may ride along with its own command handshake.
      wr_hs_cmd  = cmd_hs & ~m_cmd_read;
      wr_gate    = (wdat_cnt_q != 3'd0) | wr_hs_cmd;
      m_wr_valid = owning & w_valid & wr_gate;
      m_wr_last  = owning & (sel1 ? r1_wr_last : r0_wr_last);
      m_wr_data  = owning ? (sel1 ? r1_wr_data : r0_wr_data) : '0;
      m_wr_mask  = owning ? (sel1 ? r1_wr_mask : r0_wr_mask) : '0;
      wlast_hs   = m_wr_valid & m_wr_accept & m_wr_last;
      r0_wr_accept = own0 & m_wr_accept & wr_gate;
      r1_wr_accept = own1 & m_wr_accept & wr_gate;

      // Responses with nothing outstanding are swallowed and flagged.
      rd_ok       = (out_cnt_q != 3'd0);
      m_rd_accept = acc_idle | (owning & (rd_ok ? rd_acc : 1'b1));
      rd_fin      = owning & rd_ok & m_rd_valid & rd_acc & m_rd_last;
      rd_stray    = m_rd_valid & m_rd_accept & ~(owning & rd_ok);
      r0_rd_valid = own0 & rd_ok & m_rd_valid;
      r1_rd_valid = own1 & rd_ok & m_rd_valid;
      r0_rd_err   = r0_rd_valid & m_rd_err;
      r1_rd_err   = r1_rd_valid & m_rd_err;
      r0_rd_last  = r0_rd_valid & m_rd_last;
      r1_rd_last  = r1_rd_valid & m_rd_last;
      r0_rd_data  = own0 ? m_rd_data : '0;
      r1_rd_data  = own1 ? m_rd_data : '0;

      // A read finishing this clock consumes one outstanding slot first.
      wr_ok            = (out_cnt_q > {2'b00, rd_fin});
      m_wr_resp_accept = acc_idle | (owning & (wr_ok ? wrr_acc : 1'b1));
      wr_fin           = owning & wr_ok & m_wr_done & wrr_acc;
      wr_stray         = m_wr_done & m_wr_resp_accept & ~(owning & wr_ok);
      r0_wr_done = own0 & wr_ok & m_wr_done;
      r1_wr_done = own1 & wr_ok & m_wr_done;
      r0_wr_err  = r0_wr_done & m_wr_err;
      r1_wr_err  = r1_wr_done & m_wr_err;

      proto_err = proto_err_q;
   end

   // Next owner, round-robin pointer and traffic counters.
   always_comb begin
      owner_d     = owner_q;
      last_d      = last_q;
      out_cnt_d   = out_cnt_q + {2'b00, cmd_hs} - {2'b00, rd_fin} - {2'b00, wr_fin};
      wdat_cnt_d  = wdat_cnt_q + {2'b00, wr_hs_cmd} - {2'b00, wlast_hs};
      gnt_cnt_d   = gnt_cnt_q + {3'b000, cmd_hs};
      proto_err_d = proto_err_q | rd_stray | wr_stray;
      if (dm_active) begin
         case (owner_q)
            IDLE: begin
               if (r0_cmd_valid & (~r1_cmd_valid | last_q)) begin
                  owner_d   = OWN0;
                  last_d    = 1'b0;
                  gnt_cnt_d = 4'd0;
               end else if (r1_cmd_valid) begin
                  owner_d   = OWN1;
                  last_d    = 1'b1;
                  gnt_cnt_d = 4'd0;
               end
            end
            OWN0, OWN1: if (rel) owner_d = IDLE;
            default: owner_d = IDLE;
         endcase
      end
   end

   // State registers; async reset returns everything to idle immediately.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         owner_q     <= IDLE;
         last_q      <= 1'b1;
         out_cnt_q   <= 3'd0;
         wdat_cnt_q  <= 3'd0;
         gnt_cnt_q   <= 4'd0;
         proto_err_q <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         last_q      <= last_d;
         out_cnt_q   <= out_cnt_d;
         wdat_cnt_q  <= wdat_cnt_d;
         gnt_cnt_q   <= gnt_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule
